// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-RAM fetch/data arbiter.
// Owner encoding for the read in flight and default starvation bound.
package mem_arb_pkg;

  localparam int unsigned STARVE_LIMIT_DEF = 2;
  localparam int unsigned STARVE_CNT_W     = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and RAM port of the shared-memory arbiter.
// master = cpu/RAM side, slave = arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [MASK_W-1:0] d_mask;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_mask;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_mask,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr,
    input  mem_wdata, mem_mask,
    output mem_rdata
  );

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_mask,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr,
    output mem_wdata, mem_mask,
    input  mem_rdata
  );

endinterface

// File: rtl/starve_counter.sv
// Saturating count of data grants taken while a fetch waits.
// limit_hit hands the next cycle to the fetch port.
module starve_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_hit_o
);

  localparam logic [STARVE_CNT_W-1:0] LIM =
    STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && cnt_q != LIM) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit_o = (cnt_q == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM between fetch and load/store ports.
// Data has priority; a starvation counter bounds fetch waiting.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned MASK_W = DATA_W / 8;

  owner_t            owner_q;
  owner_t            owner_d;
  logic              limit_hit;
  logic              i_win;
  logic              i_gnt;
  logic              d_gnt;
  logic              st_gnt;
  logic [ADDR_W-1:0] addr_sel;
  logic [MASK_W-1:0] mask_sel;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk         (clk),
    .rst_n       (reset),
    .clr_i       (!bus.i_req || i_gnt),
    .inc_i       (d_gnt && bus.i_req),
    .limit_hit_o (limit_hit)
  );

  // reset gates the grants so nothing reaches the RAM during reset
  assign i_win  = bus.i_req && (limit_hit || !bus.d_req);
  assign i_gnt  = reset && i_win;
  assign d_gnt  = reset && bus.d_req && !i_win;
  assign st_gnt = d_gnt && bus.d_we;

  always_comb begin
    addr_sel = bus.d_addr;
    mask_sel = '1;
    if (i_gnt) begin
      addr_sel = bus.i_addr;
    end
    if (st_gnt) begin
      mask_sel = bus.d_mask;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    unique case (1'b1)
      i_gnt:            owner_d = OWN_INSTR;
      d_gnt && !bus.d_we: owner_d = OWN_DATA;
      default:          owner_d = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = i_gnt || d_gnt;
  assign bus.mem_we    = st_gnt;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.mem_mask  = mask_sel;

  assign bus.i_rvalid = (owner_q == OWN_INSTR);
  assign bus.d_rvalid = (owner_q == OWN_DATA);
  assign bus.i_rdata  =
    bus.i_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata  =
    bus.d_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a
// byte-masked synchronous RAM behind it.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] rd_q;
  logic [31:0] iq [$];
  logic [31:0] dq [$];

  bit ig_pat [8] = '{0, 0, 1, 0, 0, 1, 0, 0};

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (2)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_mask[b]) begin
            ram[bus.mem_addr[9:2]][b*8 +: 8]
              <= bus.mem_wdata[b*8 +: 8];
          end
        end
      end else begin
        rd_q <= ram[bus.mem_addr[9:2]];
      end
    end
  end

  assign bus.mem_rdata = rd_q;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic        ir,
    input logic [31:0] ia,
    input logic        dr,
    input logic        dw,
    input logic [31:0] da,
    input logic [31:0] dwd,
    input logic [3:0]  dm
  );
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    bus.d_mask  = dm;
  endtask

  task automatic step(
    input string       tag,
    input logic        ir,
    input logic [31:0] ia,
    input logic        dr,
    input logic        dw,
    input logic [31:0] da,
    input logic [31:0] dwd,
    input logic [3:0]  dm,
    input logic        eig,
    input logic        edg
  );
    logic [31:0] e;
    logic [31:0] w;
    @(negedge clk);
    drive(ir, ia, dr, dw, da, dwd, dm);
    #1;
    chk({tag, ".i_rvalid"}, 32'(bus.i_rvalid),
        32'(iq.size() != 0));
    e = 32'h0;
    if (iq.size() != 0) e = iq.pop_front();
    chk({tag, ".i_rdata"}, bus.i_rdata, e);
    chk({tag, ".d_rvalid"}, 32'(bus.d_rvalid),
        32'(dq.size() != 0));
    e = 32'h0;
    if (dq.size() != 0) e = dq.pop_front();
    chk({tag, ".d_rdata"}, bus.d_rdata, e);
    chk({tag, ".i_gnt"}, 32'(bus.i_gnt), 32'(eig));
    chk({tag, ".d_gnt"}, 32'(bus.d_gnt), 32'(edg));
    chk({tag, ".mem_en"}, 32'(bus.mem_en),
        32'(eig | edg));
    chk({tag, ".mem_we"}, 32'(bus.mem_we),
        32'(edg & dw));
    if (eig | edg) begin
      chk({tag, ".mem_addr"}, bus.mem_addr,
          eig ? ia : da);
      chk({tag, ".mem_mask"}, 32'(bus.mem_mask),
          (edg & dw) ? 32'(dm) : 32'hF);
    end
    if (eig) iq.push_back(ref_mem[ia[9:2]]);
    if (edg && !dw) dq.push_back(ref_mem[da[9:2]]);
    if (edg && dw) begin
      w = ref_mem[da[9:2]];
      for (int b = 0; b < 4; b++) begin
        if (dm[b]) w[b*8 +: 8] = dwd[b*8 +: 8];
      end
      ref_mem[da[9:2]] = w;
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    rd_q        = 32'h0;
    for (int k = 0; k < 256; k++) begin
      ram[k]     = 32'h0;
      ref_mem[k] = 32'h0;
    end
    ram[16]     = 32'h0000_0013;
    ref_mem[16] = 32'h0000_0013;
    for (int k = 0; k < 4; k++) begin
      ram[k]     = 32'hA000_0000 + 32'(k * 17 + 5);
      ref_mem[k] = 32'hA000_0000 + 32'(k * 17 + 5);
    end
    ram[128]     = 32'hCAFE_F00D;
    ref_mem[128] = 32'hCAFE_F00D;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);

    // reset holds grants low even with requests up
    @(negedge clk);
    drive(1, 32'h40, 1, 0, 32'h200, 32'h0, 4'h0);
    #1;
    chk("rst.i_gnt", 32'(bus.i_gnt), 32'h0);
    chk("rst.d_gnt", 32'(bus.d_gnt), 32'h0);
    chk("rst.mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst.mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst.i_rvalid", 32'(bus.i_rvalid), 32'h0);
    chk("rst.d_rvalid", 32'(bus.d_rvalid), 32'h0);
    chk("rst.i_rdata", bus.i_rdata, 32'h0);
    chk("rst.d_rdata", bus.d_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);

    // first cycle after reset: data wins, fetch next
    step("sim1", 1, 32'h40, 1, 0, 32'h200,
         32'h0, 4'h0, 0, 1);
    step("sim2", 1, 32'h40, 0, 0, 32'h0,
         32'h0, 4'h0, 1, 0);
    idle("sim3");

    step("fetch", 1, 32'h40, 0, 0, 32'h0,
         32'h0, 4'h0, 1, 0);
    idle("fetch_rv");

    step("store", 0, 32'h0, 1, 1, 32'h100,
         32'hDEAD_BEEF, 4'b0011, 0, 1);
    step("load", 0, 32'h0, 1, 0, 32'h100,
         32'h0, 4'h0, 0, 1);
    idle("load_rv");

    for (int k = 0; k < 8; k++) begin
      step($sformatf("starve%0d", k),
           1, 32'h40, 1, 0, 32'h200, 32'h0, 4'h0,
           ig_pat[k], !ig_pat[k]);
    end
    idle("starve_rv");

    for (int k = 0; k < 4; k++) begin
      step($sformatf("pipe%0d", k),
           1, 32'(k * 4), 0, 0, 32'h0, 32'h0, 4'h0,
           1, 0);
    end
    idle("pipe_rv");

    // reset lands while the fetch read is in flight
    step("midrd", 1, 32'h40, 0, 0, 32'h0,
         32'h0, 4'h0, 1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    iq.delete();
    dq.delete();
    chk("midrd.i_rvalid", 32'(bus.i_rvalid), 32'h0);
    chk("midrd.i_rdata", bus.i_rdata, 32'h0);
    chk("midrd.i_gnt", 32'(bus.i_gnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    idle("post_rst0");
    idle("post_rst1");
    step("post_fetch", 1, 32'h4, 0, 0, 32'h0,
         32'h0, 4'h0, 1, 0);
    idle("post_fetch_rv");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
